draw_text_line: RTL and testbench

- Parametrised VGA text-string renderer for game HUD labels and values ("CASH", "BET", credit digits).
- Holds a writable character buffer of up to MAX_CHARS glyph codes and renders them at (pos_x, pos_y) with power-of-two scaling.
- Supports optional blinking, a buffer-clear sweep and a registered 2-stage pixel pipeline.
- Sits between the VGA timing/pixel-coordinate generator and the colour mux; game logic drives the write port.

---
 rtl/draw_text_line_pkg.sv | 23 ++
 rtl/draw_text_line_glyph_rom.sv | 62 ++++++
 rtl/draw_text_line.sv | 145 ++++++++++++++
 tb/tb_draw_text_line.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_text_line_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_pkg : glyph geometry, glyph codes and FSM states for draw_text_line  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package text_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int CODE_W  = 6;

  typedef logic [CODE_W-1:0] glyph_code_t;

  localparam glyph_code_t G_BLANK  = 6'd0;
  localparam glyph_code_t G_DIG0   = 6'd1;
  localparam glyph_code_t G_A      = 6'd11;
  localparam glyph_code_t G_DOLLAR = 6'd37;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_t;
endpackage
`default_nettype wire

// File: rtl/draw_text_line_glyph_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | glyph_rom : combinational 64x8x8 font, bit 7 of a row is leftmost pixel   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module glyph_rom
  import text_pkg::*;
(
  input  glyph_code_t code,
  input  logic [2:0]  row,
  output logic [7:0]  bits
);
  // Each glyph packs row 0 in the top byte down to row 7 in the bottom byte.
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h0;
    case (code)
      G_DIG0:   glyph = 64'h3C666E7666663C00;
      6'd2:     glyph = 64'h1838181818187E00;
      6'd3:     glyph = 64'h3C66060C30607E00;
      6'd4:     glyph = 64'h3C66061C06663C00;
      6'd5:     glyph = 64'h0C1C3C6C7E0C0C00;
      6'd6:     glyph = 64'h7E607C0606663C00;
      6'd7:     glyph = 64'h3C607C6666663C00;
      6'd8:     glyph = 64'h7E060C1830303000;
      6'd9:     glyph = 64'h3C66663C66663C00;
      6'd10:    glyph = 64'h3C66663E060C3800;
      G_A:      glyph = 64'h183C66667E666600;
      6'd12:    glyph = 64'h7C66667C66667C00;
      6'd13:    glyph = 64'h3C66606060663C00;
      6'd14:    glyph = 64'h786C6666666C7800;
      6'd15:    glyph = 64'h7E60607C60607E00;
      6'd16:    glyph = 64'h7E60607C60606000;
      6'd17:    glyph = 64'h3C66606E66663C00;
      6'd18:    glyph = 64'h6666667E66666600;
      6'd19:    glyph = 64'h3C18181818183C00;
      6'd20:    glyph = 64'h1E0C0C0C0C6C3800;
      6'd21:    glyph = 64'h666C7870786C6600;
      6'd22:    glyph = 64'h6060606060607E00;
      6'd23:    glyph = 64'h63777F6B63636300;
      6'd24:    glyph = 64'h66767E7E6E666600;
      6'd25:    glyph = 64'h3C66666666663C00;
      6'd26:    glyph = 64'h7C66667C60606000;
      6'd27:    glyph = 64'h3C666666663C0E00;
      6'd28:    glyph = 64'h7C66667C786C6600;
      6'd29:    glyph = 64'h3E60603C06067C00;
      6'd30:    glyph = 64'h7E18181818181800;
      6'd31:    glyph = 64'h6666666666663C00;
      6'd32:    glyph = 64'h66666666663C1800;
      6'd33:    glyph = 64'h6363636B7F776300;
      6'd34:    glyph = 64'h66663C183C666600;
      6'd35:    glyph = 64'h6666663C18181800;
      6'd36:    glyph = 64'h7E060C1830607E00;
      G_DOLLAR: glyph = 64'h183E603C067C1800;
      default:  glyph = 64'h0;
    endcase
  end

  assign bits = glyph[{3'd7 - row, 3'b000} +: GLYPH_W];
endmodule
`default_nettype wire

// File: rtl/draw_text_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | draw_text_line : scaled, blinkable text string renderer, 2-cycle pipeline |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module draw_text_line
  import text_pkg::*;
#(
  parameter int MAX_CHARS    = 8,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [9:0]                                     Q_X,
  input  logic [9:0]                                     Q_Y,
  input  logic [9:0]                                     pos_x,
  input  logic [9:0]                                     pos_y,
  input  logic                                           frame_tick,
  input  logic [$clog2(MAX_CHARS+1)-1:0]                 len,
  input  logic                                           blink_en,
  input  logic                                           wr_valid,
  output logic                                           wr_ready,
  input  logic [((MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1)-1:0] wr_idx,
  input  logic [CODE_W-1:0]                              wr_code,
  input  logic                                           clr_req,
  output logic                                           busy,
  output logic                                           visible
);
  localparam int LEN_W = $clog2(MAX_CHARS + 1);
  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int S     = 1 << SCALE_LOG2;

  fsm_t              state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q;
  glyph_code_t       char_buf [MAX_CHARS];
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  blink_cnt_q;
  logic              phase_q;
  logic              wr_fire;

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = !clr_req;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx_q == IDX_W'(MAX_CHARS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_fire = wr_valid && wr_ready;

  // Out-of-range wr_idx matches no slot, so the handshake completes with no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= G_BLANK;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= (state_q == CLEAR) ? clr_idx_q + 1'b1 : '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        if (state_q == CLEAR && int'(clr_idx_q) == i) char_buf[i] <= G_BLANK;
        else if (wr_fire && int'(wr_idx) == i)       char_buf[i] <= wr_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (frame_tick) begin
      len_q <= (len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : len;
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Zone bounds in 12 bits so pos + width can never wrap back into range.
  logic [11:0] x_end, y_end;
  logic        in_x, in_y, zone_d;
  logic [9:0]  rel_x, rel_y, dx;
  logic [2:0]  col_d, row_d;
  glyph_code_t code_sel;

  assign x_end  = {2'b00, pos_x} + 12'(len_q) * 12'(GLYPH_W * S);
  assign y_end  = {2'b00, pos_y} + 12'(GLYPH_H * S);
  assign in_x   = (Q_X >= pos_x) && ({2'b00, Q_X} < x_end);
  assign in_y   = (Q_Y >= pos_y) && ({2'b00, Q_Y} < y_end);
  assign zone_d = in_x && in_y;
  assign rel_x  = in_x ? Q_X - pos_x : '0;
  assign rel_y  = in_y ? Q_Y - pos_y : '0;
  assign dx     = rel_x >> SCALE_LOG2;
  assign col_d  = dx[2:0];
  assign row_d  = 3'(rel_y >> SCALE_LOG2);

  always_comb begin
    code_sel = G_BLANK;
    for (int i = 0; i < MAX_CHARS; i++)
      if (int'(dx[9:3]) == i) code_sel = char_buf[i];
  end

  logic        zone_q;
  logic [2:0]  col_q, row_q;
  glyph_code_t code_q;
  logic [7:0]  rom_bits;

  glyph_rom u_rom (
    .code (code_q),
    .row  (row_q),
    .bits (rom_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= G_BLANK;
      visible <= 1'b0;
    end else begin
      zone_q  <= zone_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_sel;
      visible <= zone_q && rom_bits[3'd7 - col_q] && !(blink_en && phase_q);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_draw_text_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_draw_text_line : three parameter variants against a behavioural model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_draw_text_line;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] qx = '0, qy = '0;
  logic [9:0] px = 10'd100, py = 10'd50;
  logic       tick = 1'b0, blink_en = 1'b0, wr_valid = 1'b0, clr_req = 1'b0;
  logic [3:0] len = '0, wr_idx = '0;
  logic [5:0] wr_code = '0;
  logic [2:0] vis, busy, rdy;
  int tests = 0, fails = 0;
  int ys [7] = '{49, 50, 53, 57, 58, 65, 66};

  always #5 clk = ~clk;

  draw_text_line #(.MAX_CHARS(8), .SCALE_LOG2(0), .BLINK_FRAMES(2)) u_d0 (
    .clk(clk), .rst(rst), .Q_X(qx), .Q_Y(qy), .pos_x(px), .pos_y(py),
    .frame_tick(tick), .len(len), .blink_en(blink_en), .wr_valid(wr_valid),
    .wr_ready(rdy[0]), .wr_idx(wr_idx[2:0]), .wr_code(wr_code),
    .clr_req(clr_req), .busy(busy[0]), .visible(vis[0]));
  draw_text_line #(.MAX_CHARS(8), .SCALE_LOG2(1), .BLINK_FRAMES(2)) u_d1 (
    .clk(clk), .rst(rst), .Q_X(qx), .Q_Y(qy), .pos_x(px), .pos_y(py),
    .frame_tick(tick), .len(len), .blink_en(blink_en), .wr_valid(wr_valid),
    .wr_ready(rdy[1]), .wr_idx(wr_idx[2:0]), .wr_code(wr_code),
    .clr_req(clr_req), .busy(busy[1]), .visible(vis[1]));
  draw_text_line #(.MAX_CHARS(9), .SCALE_LOG2(0), .BLINK_FRAMES(2)) u_d2 (
    .clk(clk), .rst(rst), .Q_X(qx), .Q_Y(qy), .pos_x(px), .pos_y(py),
    .frame_tick(tick), .len(len), .blink_en(blink_en), .wr_valid(wr_valid),
    .wr_ready(rdy[2]), .wr_idx(wr_idx), .wr_code(wr_code),
    .clr_req(clr_req), .busy(busy[2]), .visible(vis[2]));

  task automatic chk(string name, logic [31:0] act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int maxc(int d); return (d == 2) ? 9 : 8; endfunction
  function automatic int slog(int d); return (d == 1) ? 1 : 0; endfunction

  // Only the glyphs this bench writes; rows top to bottom, MSB leftmost.
  function automatic logic [63:0] font(int c);
    case (c)
      11:      return 64'h183C66667E666600;
      13:      return 64'h3C66606060663C00;
      18:      return 64'h6666667E66666600;
      29:      return 64'h3E60603C06067C00;
      default: return 64'h0;
    endcase
  endfunction

  int mbuf [3][16];
  int mlen [3], mclr [3], ms1 [3], mvis [3];
  int mcnt = 0, mphase = 0;
  bit mvalid = 1'b0;

  function automatic int pix(int d, int x, int y);
    int s, ox, oy, dxx, ch, col, row;
    logic [63:0] g;
    s  = 1 << slog(d);
    ox = int'(px);
    oy = int'(py);
    if (x < ox || x >= ox + mlen[d] * 8 * s || y < oy || y >= oy + 8 * s) return 0;
    dxx = (x - ox) / s;
    ch  = dxx / 8;
    col = dxx % 8;
    row = ((y - oy) / s) % 8;
    g   = font(mbuf[d][ch]);
    return int'(g[63 - row * 8 - col]);
  endfunction

  // Check outputs for the current cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("vis%0d", d), {31'b0, vis[d]}, mvis[d]);
        chk($sformatf("busy%0d", d), {31'b0, busy[d]}, (mclr[d] > 0) ? 1 : 0);
        chk($sformatf("rdy%0d", d), {31'b0, rdy[d]}, (mclr[d] == 0 && !clr_req) ? 1 : 0);
      end
    end
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 16; k++) mbuf[d][k] = 0;
        mlen[d] = 0; mclr[d] = 0; ms1[d] = 0; mvis[d] = 0;
      end
      mcnt = 0; mphase = 0; mvalid = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        int np, idx;
        np = pix(d, int'(qx), int'(qy));
        mvis[d] = (ms1[d] != 0 && !(blink_en && mphase != 0)) ? 1 : 0;
        ms1[d] = np;
        if (mclr[d] > 0) begin
          mbuf[d][maxc(d) - mclr[d]] = 0;
          mclr[d]--;
        end else if (clr_req) begin
          mclr[d] = maxc(d);
        end else if (wr_valid) begin
          idx = (d < 2) ? int'(wr_idx) % 8 : int'(wr_idx);
          if (idx < maxc(d)) mbuf[d][idx] = int'(wr_code);
        end
        if (tick) mlen[d] = (int'(len) > maxc(d)) ? maxc(d) : int'(len);
      end
      if (tick) begin
        if (mcnt == 1) begin mcnt = 0; mphase ^= 1; end
        else mcnt++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic probe(int x, int y, int e0, int e1, int e2, string nm);
    qx = 10'(x); qy = 10'(y);
    step(2);
    @(negedge clk);
    chk({nm, "_d0"}, {31'b0, vis[0]}, e0);
    chk({nm, "_d1"}, {31'b0, vis[1]}, e1);
    chk({nm, "_d2"}, {31'b0, vis[2]}, e2);
    step(1);
  endtask

  task automatic wr(int idx, int code);
    wr_valid = 1'b1; wr_idx = 4'(idx); wr_code = 6'(code);
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    int n0, n2;
    bit wrote;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vis%0d", d), {31'b0, vis[d]}, 0);
      chk($sformatf("rst_busy%0d", d), {31'b0, busy[d]}, 0);
      chk($sformatf("rst_rdy%0d", d), {31'b0, rdy[d]}, 1);
    end
    step(1);

    len = 4'd4;
    probe(102, 50, 0, 0, 0, "pre_tick");
    wr(0, 13); wr(1, 11); wr(2, 29); wr(3, 18);
    do_tick();
    chk("pin_model_a", pix(0, 111, 50), 1);
    chk("pin_model_b", pix(1, 103, 50), 0);

    probe(102, 50, 1, 0, 1, "c_col2");
    probe(100, 50, 0, 0, 0, "c_col0");
    probe(111, 50, 1, 1, 1, "a_col3");
    probe(132, 50, 0, 0, 0, "past_end");
    probe(104, 50, 1, 1, 1, "x104");
    probe(105, 51, 1, 1, 1, "x105y51");
    probe(103, 50, 1, 0, 1, "x103");
    probe(164, 50, 0, 0, 0, "x_zone_end");
    probe(150, 66, 0, 0, 0, "y_zone_end");

    foreach (ys[j]) begin
      qy = 10'(ys[j]);
      for (int x = 98; x <= 166; x++) begin qx = 10'(x); step(1); end
    end

    blink_en = 1'b1;
    probe(104, 50, 1, 1, 1, "blink_t1");
    do_tick(); probe(104, 50, 0, 0, 0, "blink_t2");
    do_tick(); probe(104, 50, 0, 0, 0, "blink_t3");
    do_tick(); probe(104, 50, 1, 1, 1, "blink_t4");
    do_tick(); do_tick();
    probe(104, 50, 0, 0, 0, "blink_t6_en");
    blink_en = 1'b0;
    probe(104, 50, 1, 1, 1, "blink_t6_dis");

    clr_req = 1'b1; wr_valid = 1'b1; wr_idx = 4'd4; wr_code = 6'd11;
    @(negedge clk);
    chk("clr_beats_wr", {31'b0, rdy[0]}, 0);
    chk("clr_busy_pre", {31'b0, busy[0]}, 0);
    step(1);
    clr_req = 1'b0; wr_valid = 1'b0;
    n0 = 0; n2 = 0; wrote = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n0 += int'(busy[0]);
      n2 += int'(busy[2]);
      if (!busy[0] && n0 > 0 && !wrote) begin
        wr_valid = 1'b1; wr_idx = 4'd0; wr_code = 6'd13; wrote = 1'b1;
        @(negedge clk);
        chk("wr_on_busy_fall", {31'b0, rdy[0]}, 1);
      end else begin
        wr_valid = 1'b0;
      end
      step(1);
    end
    wr_valid = 1'b0;
    chk("busy_len_d0", n0, 8);
    chk("busy_len_d2", n2, 9);
    chk("busy_fell", {31'b0, wrote}, 1);
    probe(104, 50, 1, 1, 0, "after_clr");
    probe(111, 50, 0, 1, 0, "after_clr_s1");

    wr_valid = 1'b1; wr_idx = 4'd9; wr_code = 6'd11;
    @(negedge clk);
    chk("oor_ready", {31'b0, rdy[2]}, 1);
    step(1);
    wr_valid = 1'b0;
    probe(111, 50, 1, 1, 0, "oor_dropped");

    len = 4'd12;
    do_tick();
    chk("clamp_d0", {28'b0, u_d0.len_q}, 8);
    chk("clamp_d2", {28'b0, u_d2.len_q}, 9);
    qy = 10'd50;
    for (int x = 98; x <= 180; x++) begin qx = 10'(x); step(1); end

    clr_req = 1'b1; step(1); clr_req = 1'b0;
    step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy[0]}, 0);
    chk("rst_mid_vis", {31'b0, vis[0]}, 0);
    chk("rst_mid_rdy", {31'b0, rdy[0]}, 1);
    step(1);
    probe(104, 50, 0, 0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
